// File: rtl/stack_seq_pkg.sv
`default_nettype none
// ============================================================================
//  stack_seq_pkg
//  Shared opcodes, FSM state encoding and signed-limit helpers for the
//  stack ALU command sequencer.
//  Revision: 1.0
// ============================================================================
package stack_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH     = 3'd1,
    POP      = 3'd2,
    OP       = 3'd3,
    POP1     = 3'd4,
    POP2     = 3'd5,
    PUSH_RES = 3'd6,
    ERR      = 3'd7
  } state_e;

  // Low n bits of the result hold the n-bit two's complement limit.
  function automatic logic [31:0] signed_max(input int unsigned n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] signed_min(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_seq_saturate.sv
`default_nettype none
// ============================================================================
//  stack_seq_saturate
//  Clamps an overflowed ALU result to the signed limit matching the sign of
//  the exact result. Used only when STACK_SEQ_SATURATE_EN is defined.
//  Revision: 1.0
// ============================================================================
module stack_seq_saturate
  import stack_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_r,
  input  logic         i_v,
  input  logic         i_a_sign,
  input  logic         i_b_sign,
  input  logic [2:0]   i_op,
  output logic [N-1:0] o_p
);

  logic w_neg;

  always_comb begin
    // On overflow the exact sum shares A's sign; the exact product's sign is A^B.
    w_neg = (i_op == OP_MUL) ? (i_a_sign ^ i_b_sign) : i_a_sign;
    o_p   = i_r;
    if (i_v) begin
      o_p = w_neg ? N'(signed_min(N)) : N'(signed_max(N));
    end
  end

endmodule
`default_nettype wire

// File: rtl/stack_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  stack_alu_sequencer
//  RPN command front end for stack_base_alu: depth tracking, ADD/MUL expansion
//  into op/pop/pop/push, result return. Optional STACK_SEQ_SATURATE_EN.
//  Revision: 1.0
// ============================================================================
module stack_alu_sequencer
  import stack_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 201
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_opcode,
  input  logic [N-1:0]               cmd_data,
  output logic [2:0]                 alu_opcode,
  output logic [N-1:0]               alu_input_data,
  input  logic [N-1:0]               alu_output_data,
  input  logic                       alu_overflow,
  output logic                       res_valid,
  output logic [N-1:0]               res_data,
  output logic                       res_overflow,
  output logic                       err,
  output logic                       ovf_sticky,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam logic [DEPTH_W-1:0] c_depth_full = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] c_depth_one  = DEPTH_W'(1);

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic [2:0]           alu_opcode_q, alu_opcode_d;
  logic [N-1:0]         alu_input_data_q, alu_input_data_d;
  logic                 res_valid_q, res_valid_d;
  logic [N-1:0]         res_data_q, res_data_d;
  logic                 res_overflow_q, res_overflow_d;
  logic                 err_q, err_d;
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [N-1:0]         r_q, r_d;
  logic                 v_q, v_d;
  logic                 w_xfer;
  logic [N-1:0]         w_p;

  assign w_xfer         = cmd_valid && cmd_ready_q;
  assign cmd_ready      = cmd_ready_q;
  assign alu_opcode     = alu_opcode_q;
  assign alu_input_data = alu_input_data_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_overflow   = res_overflow_q;
  assign err            = err_q;
  assign ovf_sticky     = ovf_sticky_q;
  assign depth          = depth_q;

`ifdef STACK_SEQ_SATURATE_EN
  logic       a_sign_q, a_sign_d;
  logic [2:0] op_q, op_d;

  always_comb begin
    a_sign_d = a_sign_q;
    op_d     = op_q;
    if (state_q == POP1) a_sign_d = alu_output_data[N-1];
    if (state_q == IDLE && w_xfer) op_d = cmd_opcode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sign_q <= 1'b0;
      op_q     <= OP_NOP;
    end else begin
      a_sign_q <= a_sign_d;
      op_q     <= op_d;
    end
  end

  // B arrives live from the ALU during POP2, the cycle P is computed.
  stack_seq_saturate #(.N(N)) u_saturate (
    .i_r      (r_q),
    .i_v      (v_q),
    .i_a_sign (a_sign_q),
    .i_b_sign (alu_output_data[N-1]),
    .i_op     (op_q),
    .o_p      (w_p)
  );
`else
  assign w_p = r_q;
`endif

  always_comb begin
    state_d        = state_q;
    depth_d        = depth_q;
    res_valid_d    = 1'b0;
    res_data_d     = res_data_q;
    res_overflow_d = res_overflow_q;
    ovf_sticky_d   = ovf_sticky_q;
    r_d            = r_q;
    v_d            = v_q;

    case (state_q)
      IDLE: begin
        if (w_xfer) begin
          case (cmd_opcode)
            OP_NOP:         state_d = IDLE;
            OP_PUSH:        state_d = (depth_q == c_depth_full) ? ERR : PUSH;
            OP_POP:         state_d = (depth_q == '0) ? ERR : POP;
            OP_ADD, OP_MUL: state_d = (depth_q <= c_depth_one) ? ERR : OP;
            default:        state_d = ERR;
          endcase
        end
      end
      PUSH: begin
        depth_d = depth_q + c_depth_one;
        state_d = IDLE;
      end
      POP: begin
        res_data_d     = alu_output_data;
        res_overflow_d = 1'b0;
        res_valid_d    = 1'b1;
        depth_d        = depth_q - c_depth_one;
        state_d        = IDLE;
      end
      OP: begin
        r_d     = alu_output_data;
        v_d     = alu_overflow;
        state_d = POP1;
      end
      POP1: begin
        depth_d = depth_q - c_depth_one;
        state_d = POP2;
      end
      POP2: begin
        depth_d = depth_q - c_depth_one;
        state_d = PUSH_RES;
      end
      PUSH_RES: begin
        depth_d        = depth_q + c_depth_one;
        res_data_d     = alu_input_data_q;
        res_overflow_d = v_q;
        res_valid_d    = 1'b1;
        ovf_sticky_d   = ovf_sticky_q | v_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered ALU drive: decode the state being entered.
    cmd_ready_d      = (state_d == IDLE);
    err_d            = (state_d == ERR);
    alu_opcode_d     = OP_NOP;
    alu_input_data_d = '0;
    case (state_d)
      PUSH: begin
        alu_opcode_d     = OP_PUSH;
        alu_input_data_d = cmd_data;
      end
      POP, POP1, POP2: alu_opcode_d = OP_POP;
      OP:              alu_opcode_d = cmd_opcode;
      PUSH_RES: begin
        alu_opcode_d     = OP_PUSH;
        alu_input_data_d = w_p;
      end
      default: alu_opcode_d = OP_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cmd_ready_q      <= 1'b0;
      alu_opcode_q     <= OP_NOP;
      alu_input_data_q <= '0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_overflow_q   <= 1'b0;
      err_q            <= 1'b0;
      ovf_sticky_q     <= 1'b0;
      depth_q          <= '0;
      r_q              <= '0;
      v_q              <= 1'b0;
    end else begin
      state_q          <= state_d;
      cmd_ready_q      <= cmd_ready_d;
      alu_opcode_q     <= alu_opcode_d;
      alu_input_data_q <= alu_input_data_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
      res_overflow_q   <= res_overflow_d;
      err_q            <= err_d;
      ovf_sticky_q     <= ovf_sticky_d;
      depth_q          <= depth_d;
      r_q              <= r_d;
      v_q              <= v_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

Command-level controller in front of the stack-based ALU (`stack_base_alu`). Accepts RPN commands over a valid/ready handshake and tracks stack depth so that no illegal push, pop or arithmetic reaches the ALU. Expands each ADD/MUL into the ALU command sequence that consumes both operands and pushes the result. Returns results and overflow status to the requester.

## Interface
- `N`, 8: data width; must match the ALU's `N`.
- `DEPTH`, 201: ALU stack capacity in entries.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_opcode`  in  3  000 NOP, 100 ADD, 101 MUL, 110 PUSH, 111 POP; all other codes are illegal.
- `cmd_data`  in  N  signed operand; PUSH only.
- `alu_opcode`  out  3  drives ALU `opcode`; 000 when idle.
- `alu_input_data`  out  N  drives ALU `input_data`.
- `alu_output_data`  in  N  ALU `output_data`.
- `alu_overflow`  in  1  ALU `overflow`.
- `res_valid`  out  1  one-cycle pulse; `res_data`/`res_overflow` valid.
- `res_data`  out  N  POP value or arithmetic result as pushed.
- `res_overflow`  out  1  arithmetic overflowed (always 0 for POP).
- `err`  out  1  one-cycle pulse: command rejected.
- `ovf_sticky`  out  1  set by any arithmetic overflow; cleared only by `rst`.
- `depth`  out  $clog2(DEPTH+1)  current ALU stack occupancy.

## Operation
- FSM states: IDLE, PUSH, POP, OP, POP1, POP2, PUSH_RES, ERR.
- Handshake: a command transfers when `cmd_valid && cmd_ready`. `cmd_ready` = 1 only in IDLE (not in reset).
- Decode happens in IDLE on transfer:
  - NOP: no ALU activity; FSM stays in IDLE.
  - PUSH: if `depth == DEPTH`, go to ERR; else latch `cmd_data` and go to PUSH.
  - POP: if `depth == 0`, go to ERR; else go to POP.
  - ADD/MUL: if `depth < 2`, go to ERR; else latch the opcode and go to OP.
  - Illegal opcode: go to ERR.
- PUSH: `alu_opcode`=110 and `alu_input_data`=latched data for one cycle; `depth`+1; return to IDLE.
- POP: `alu_opcode`=111 for one cycle; sample `alu_output_data` into `res_data`; `depth`-1; pulse `res_valid` next cycle; return to IDLE.
- OP: `alu_opcode`=latched op for one cycle; capture result R and overflow V.
- POP1: issue 111 and capture operand A; `depth`-1.
- POP2: issue 111 and capture operand B; `depth`-1.
- PUSH_RES: issue 110 with the value P (below); `depth`+1; set `res_data`=P, `res_overflow`=V; pulse `res_valid` next cycle; OR V into `ovf_sticky`; return to IDLE.
- ERR: `err`=1 for one cycle; no ALU command; `depth` unchanged; return to IDLE.
- Arithmetic: R is N-bit two's complement, wrapped, exactly as the ALU produces it. P = R unless saturation is enabled (see Configuration).
- `alu_opcode` is 000 in every state that issues no ALU command.

## Timing
- Registered outputs. Reset values: `cmd_ready`=0 during reset and 1 the first cycle after; `alu_opcode`=0, `alu_input_data`=0, `res_valid`=0, `res_data`=0, `res_overflow`=0, `err`=0, `ovf_sticky`=0, `depth`=0.
- Cycle counts from the transfer cycle T:
  - PUSH: ALU command at T+1; `cmd_ready` at T+2.
  - POP: ALU command at T+1; `res_valid` at T+2 and `cmd_ready` at T+2.
  - ADD/MUL: ALU commands at T+1..T+4; `res_valid` at T+5 and `cmd_ready` at T+5.
  - ERR: `err` at T+1; `cmd_ready` at T+2.
- ALU outputs are sampled in the same cycle as the command that produces them, since the ALU is combinational.
- Reset mid-sequence: the FSM returns to IDLE and `depth` goes to 0. The ALU's internal pointer is not reset by this block; system reset must reset both.
- Commands offered while `cmd_ready`=0 are held by the requester and not consumed.

## Configuration
- `STACK_SEQ_SATURATE_EN` defined: when V=1, P saturates to the signed maximum or minimum. The sign is taken from A for ADD and from A^B for MUL. `res_overflow` still reports 1.
- Not defined: P = R (wrap); saturation logic is absent.

## Structure
- Package `stack_seq_pkg` holds:
  - opcode localparams `OP_NOP`, `OP_ADD`, `OP_MUL`, `OP_PUSH`, `OP_POP`;
  - the FSM state enum;
  - signed max/min helper functions of `N`.
- One sub-module: `stack_seq_saturate`, combinational (R, V, A, B, op -> P), instantiated only under `STACK_SEQ_SATURATE_EN`.

## Test plan
- PUSH 3, PUSH 4, ADD, POP (N=8) -> `res_data`=7 with `res_overflow`=0 after the ADD; POP returns 7; `depth` ends at 0.
- PUSH 100, PUSH 50, ADD -> wrap build: `res_data`=-106 with `res_overflow`=1; saturate build: `res_data`=127. `ovf_sticky`=1 in both builds.
- PUSH -16, PUSH 16, MUL -> wrap build: `res_data`=0 with `res_overflow`=1; saturate build: `res_data`=-128.
- POP at `depth`=0, ADD at `depth`=1, opcode 010 -> `err` pulse at T+1 in each case; `depth` unchanged; `alu_opcode` stays 000.
- 201 PUSHes, then a 202nd PUSH -> the last PUSH raises `err`; `depth`=201; the ALU sees exactly 201 pushes.
- Assert `rst` during POP1 of a MUL -> next cycle: FSM in IDLE, `depth`=0, `res_valid`=0, `cmd_ready`=1 one cycle after reset is released.
